// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit: opcodes, ALU codes,
// FSM states, datapath select codes, trap causes and the registered decode fields.
package rv_ctrl_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd15;

  // PC source select
  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_ALU  = 2'd1;
  localparam logic [1:0] PC_SEL_TRAP = 2'd2;

  // Writeback source select
  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Memory access sizes
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Load data extension
  localparam logic [2:0] LEXT_NONE = 3'd0;
  localparam logic [2:0] LEXT_LW   = 3'd1;
  localparam logic [2:0] LEXT_LB   = 3'd2;
  localparam logic [2:0] LEXT_LH   = 3'd3;
  localparam logic [2:0] LEXT_LBU  = 3'd4;
  localparam logic [2:0] LEXT_LHU  = 3'd5;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_BUS     = 2'd2;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_JUMP   = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4
  } cls_e;

  // Fields captured in DECODE and replayed in EXEC/MEM/WB
  typedef struct packed {
    cls_e       cls;
    logic [2:0] funct3;
    logic [3:0] alu_control;
    logic [2:0] imm_type;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] wb_sel;
    logic [1:0] mem_size;
    logic [2:0] load_ext;
    logic       br_un;
  } decode_t;

  // Map funct3 (plus the alternate bit) onto an ALU code
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Branch outcome from funct3 and the comparator flags
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I decoder: turns an instruction word into the decode field
// struct consumed by the control FSM, and flags encodings the core cannot run.
module rv_decode
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register and immediate fields belong to the datapath, not the control unit
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  // Field decode per opcode class
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis infers a latch to hold it.
    dec             = '0;
    dec.cls         = CLS_ALU;
    dec.funct3      = funct3;
    dec.alu_control = ALU_ADD;
    illegal         = 1'b0;

    case (opcode)
      OP_REG: begin
        dec.wb_sel = WB_ALU;
        if (funct7 == 7'b0000000) begin
          dec.alu_control = alu_from_f3(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.alu_control = alu_from_f3(funct3, 1'b1);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        dec.b_sel       = 1'b1;
        dec.imm_type    = IMM_I;
        dec.wb_sel      = WB_ALU;
        dec.alu_control = alu_from_f3(funct3, funct3 == 3'b101 && instr[30]);
      end
      OP_LUI: begin
        dec.alu_control = ALU_LUI;
        dec.b_sel       = 1'b1;
        dec.imm_type    = IMM_U;
        dec.wb_sel      = WB_ALU;
      end
      OP_AUIPC: begin
        dec.a_sel    = 1'b1;
        dec.b_sel    = 1'b1;
        dec.imm_type = IMM_U;
        dec.wb_sel   = WB_ALU;
      end
      OP_JAL: begin
        dec.cls      = CLS_JUMP;
        dec.a_sel    = 1'b1;
        dec.b_sel    = 1'b1;
        dec.imm_type = IMM_J;
        dec.wb_sel   = WB_PC4;
      end
      OP_JALR: begin
        dec.cls      = CLS_JUMP;
        dec.b_sel    = 1'b1;
        dec.imm_type = IMM_I;
        dec.wb_sel   = WB_PC4;
      end
      OP_BRANCH: begin
        dec.cls      = CLS_BRANCH;
        dec.a_sel    = 1'b1;
        dec.b_sel    = 1'b1;
        dec.imm_type = IMM_B;
        dec.br_un    = funct3[1];
        illegal      = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        dec.cls      = CLS_LOAD;
        dec.b_sel    = 1'b1;
        dec.imm_type = IMM_I;
        dec.wb_sel   = WB_MEM;
        case (funct3)
          3'b000:  begin dec.mem_size = SIZE_B; dec.load_ext = LEXT_LB;  end
          3'b001:  begin dec.mem_size = SIZE_H; dec.load_ext = LEXT_LH;  end
          3'b010:  begin dec.mem_size = SIZE_W; dec.load_ext = LEXT_LW;  end
          3'b100:  begin dec.mem_size = SIZE_B; dec.load_ext = LEXT_LBU; end
          3'b101:  begin dec.mem_size = SIZE_H; dec.load_ext = LEXT_LHU; end
          default: illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec.cls      = CLS_STORE;
        dec.b_sel    = 1'b1;
        dec.imm_type = IMM_S;
        dec.mem_size = funct3[1:0];
        illegal      = (funct3 > 3'd2);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_mc_controller.sv
// Multi-cycle RV32I control unit. Sequences FETCH/DECODE/EXEC/MEM/WB, waits on
// the shared memory handshake with a bounded timeout, and traps on illegal
// instructions or bus timeouts. Each instruction writes the PC exactly once.
module rv_mc_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        eq,
  input  logic        lt,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        br_un,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [2:0]  load_ext,
  output logic        iord,
  output logic [3:0]  alu_control,
  output logic [2:0]  imm_type,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  wb_sel,
  output logic        reg_we,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  // Counter value in the last tolerated wait cycle
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  decode_t    dec, dec_q;
  logic       illegal;
  logic [1:0] cause_q, cause_d;
  logic [7:0] wait_cnt;
  logic       timeout;

  rv_decode u_decode (
    .instr   (instr),
    .dec     (dec),
    .illegal (illegal)
  );

  // A ready in the final wait cycle completes the access instead of trapping
  assign timeout    = TRAP_EN && !mem_ready && (wait_cnt == TIMEOUT_LAST);
  assign state      = state_q;
  assign trap_cause = cause_q;

  // State, decode capture, trap cause and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      dec_q    <= '0;
      cause_q  <= CAUSE_NONE;
      wait_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; blocking ones would make results depend on statement order.
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == S_DECODE) dec_q <= dec;
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready &&
                   wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Next-state and Moore/handshake outputs
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_SEL_PC4;
    br_un       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_size    = SIZE_B;
    load_ext    = LEXT_NONE;
    iord        = 1'b0;
    alu_control = ALU_ADD;
    imm_type    = IMM_I;
    a_sel       = 1'b0;
    b_sel       = 1'b0;
    wb_sel      = WB_MEM;
    reg_we      = 1'b0;
    trap        = 1'b0;

    // Registered ALU controls are replayed in every post-decode state
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_control = dec_q.alu_control;
      imm_type    = dec_q.imm_type;
      a_sel       = dec_q.a_sel;
      b_sel       = dec_q.b_sel;
    end

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_size = SIZE_W;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_DECODE: begin
        if (!illegal) begin
          state_d = S_EXEC;
        end else if (TRAP_EN) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          // Illegal encodings retire as a NOP
          pc_we   = 1'b1;
          pc_sel  = PC_SEL_PC4;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        case (dec_q.cls)
          CLS_BRANCH: begin
            br_un   = dec_q.br_un;
            pc_we   = 1'b1;
            pc_sel  = branch_taken(dec_q.funct3, eq, lt) ? PC_SEL_ALU : PC_SEL_PC4;
            state_d = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we   = (dec_q.cls == CLS_STORE);
        mem_size = dec_q.mem_size;
        load_ext = dec_q.load_ext;
        if (mem_ready) begin
          if (dec_q.cls == CLS_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_SEL_PC4;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        pc_we    = 1'b1;
        wb_sel   = dec_q.wb_sel;
        mem_size = dec_q.mem_size;
        load_ext = dec_q.load_ext;
        pc_sel   = (dec_q.cls == CLS_JUMP) ? PC_SEL_ALU : PC_SEL_PC4;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        trap    = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = PC_SEL_TRAP;
        state_d = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule
